// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder on the load/store path.
// Accepts one request at a time over a valid/ready handshake, accesses an
// internal word-organised RAM with byte lanes and returns lane-shifted,
// sign/zero-extended load data after LATENCY cycles.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  responder can accept (IDLE only)
//   req_we     in   1 = store, 0 = load
//   req_addr   in   32-bit byte address
//   req_func3  in   RV32I load/store func3
//   req_wdata  in   store data, relevant byte/half in the low bits
//   rsp_valid  out  response present, held until rsp_ready
//   rsp_ready  in   requester takes response
//   rsp_rdata  out  extended load data; 0 for stores and errors
//   rsp_err    out  misaligned / illegal func3 / out-of-range access
//
// Optional feature (macro DMEM_ERR_STICKY_EN):
//   err_sticky out  set on the first faulting acceptance, held until reset
//   err_addr   out  req_addr of that first fault
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_ERR_STICKY_EN
    ,
    output logic        err_sticky,
    output logic [31:0] err_addr
`endif
);

    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    // WAIT lasts cnt+1 cycles, i.e. LATENCY-1 cycles in total.
    localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic        err_pend_q;
    logic [31:0] ld_data_q;

    logic [31:0] mem [DEPTH];

    logic                  accept;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic                  illegal_f3;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  req_err;
    logic [3:0]            be;
    logic [31:0]           wdata_rep;
    logic [31:0]           rd_word;
    logic [31:0]           rd_shift;
    logic [31:0]           ld_ext;
    logic [31:0]           ld_val;

    assign accept   = req_valid && req_ready_q;
    assign word_idx = req_addr[ADDR_WIDTH+1:2];
    assign lane     = req_addr[1:0];

    // Error classification of the request currently presented.
    always_comb begin
        illegal_f3 = 1'b0;
        if (req_we) begin
            illegal_f3 = (req_func3 >= 3'b011);
        end else begin
            illegal_f3 = (req_func3 == 3'b011) || (req_func3 == 3'b110) ||
                         (req_func3 == 3'b111);
        end
        misaligned   = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = |req_addr[31:ADDR_WIDTH+2];
        req_err      = illegal_f3 || misaligned || out_of_range;
    end

    // Store byte enables and lane-replicated write data.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = req_wdata;
        case (req_func3[1:0])
            2'b00: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be        = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = req_wdata;
            end
        endcase
    end

    // Load path: lane shift to bit 0, then sign/zero extension.
    always_comb begin
        rd_word  = mem[word_idx];
        rd_shift = rd_word >> {lane, 3'b000};
        case (req_func3)
            3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_ext = {24'd0, rd_shift[7:0]};
            3'b101:  ld_ext = {16'd0, rd_shift[15:0]};
            default: ld_ext = rd_word;
        endcase
        ld_val = (req_we || req_err) ? '0 : ld_ext;
    end

    // RAM: no reset; stores commit on the acceptance edge.
    always_ff @(posedge clk) begin
        if (rst && accept && req_we && !req_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    // Load data is resolved at acceptance rather than capturing the request
    // fields: only one request is in flight, so no store can intervene.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            err_pend_q  <= 1'b0;
            ld_data_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        ld_data_q   <= ld_val;
                        err_pend_q  <= req_err;
                        if (LATENCY > 1) begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_INIT;
                        end else begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= ld_val;
                            rsp_err_q   <= req_err;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= ld_data_q;
                        rsp_err_q   <= err_pend_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef DMEM_ERR_STICKY_EN
    logic        err_sticky_q;
    logic [31:0] err_addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
        end else if (accept && req_err && !err_sticky_q) begin
            err_sticky_q <= 1'b1;
            err_addr_q   <= req_addr;
        end
    end

    assign err_sticky = err_sticky_q;
    assign err_addr   = err_addr_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int unsigned AW  = 10;
    localparam int unsigned LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_func3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_ERR_STICKY_EN
    logic        err_sticky;
    logic [31:0] err_addr;
`endif

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_func3 (req_func3),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
`ifdef DMEM_ERR_STICKY_EN
        ,
        .err_sticky(err_sticky),
        .err_addr  (err_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: 64-byte array covering the randomised region.
    logic [7:0] mb [64];

    task automatic ref_access(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                              input logic [31:0] wd, output logic [31:0] rd, output bit err);
        int size;
        logic [31:0] v;
        bit illegal, mis, oor;
        size    = 1 << (f3 % 4);
        illegal = we ? (f3 > 2) : (f3 == 3 || f3 > 5);
        mis     = (size <= 4) && ((addr % size) != 0);
        oor     = addr >= (32'd4 << AW);
        err     = illegal || mis || oor;
        rd      = 0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < size; k++) mb[addr + k] = 8'(wd >> (8 * k));
            end else begin
                v = 0;
                for (int k = 0; k < size; k++) v = v | (32'(mb[addr + k]) << (8 * k));
                if (f3 < 4 && size < 4 && v[8 * size - 1])
                    v = v | ~((32'd1 << (8 * size)) - 1);
                rd = v;
            end
        end
    endtask

    // One full transaction with rsp_ready held high; starts and ends at a negedge.
    task automatic do_req(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err,
                          input string tag);
        int n;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_func3 = f3; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk({tag, " accept_timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        // scramble inputs after acceptance; they must have no effect
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_func3 = 3'($urandom); req_wdata = $urandom;
        n = 1;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk({tag, " latency"}, 32'(n), 32'(LAT));
        chk({tag, " rdata"}, rsp_rdata, exp_rd);
        chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, " ready_busy"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        chk({tag, " leave_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " leave_rdata"}, {rsp_rdata[31:1], rsp_rdata[0] | rsp_err}, 32'd0);
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [31:0] erd;
        bit          eerr;
        logic [31:0] a;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] wd;
        int          n;

        vecs[0]  = '{1'b1, 32'h10,   3'b010, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,   3'b010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h13,   3'b000, 32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[3]  = '{1'b0, 32'h13,   3'b100, 32'h0,        32'h000000DE, 1'b0};
        vecs[4]  = '{1'b0, 32'h12,   3'b001, 32'h0,        32'hFFFFDEAD, 1'b0};
        vecs[5]  = '{1'b0, 32'h10,   3'b101, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[6]  = '{1'b1, 32'h11,   3'b000, 32'hFFFFFF55, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 32'h10,   3'b010, 32'h0,        32'hDEAD55EF, 1'b0};
        vecs[8]  = '{1'b1, 32'h12,   3'b001, 32'hABCD1234, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'h10,   3'b010, 32'h0,        32'h123455EF, 1'b0};
        vecs[10] = '{1'b0, 32'h02,   3'b010, 32'h0,        32'h0,        1'b1};
        vecs[11] = '{1'b1, 32'h01,   3'b001, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[12] = '{1'b0, 32'h10,   3'b011, 32'h0,        32'h0,        1'b1};
        vecs[13] = '{1'b0, 32'h4000, 3'b010, 32'h0,        32'h0,        1'b1};
        vecs[14] = '{1'b1, 32'h10,   3'b011, 32'h0,        32'h0,        1'b1};
        vecs[15] = '{1'b0, 32'h10,   3'b010, 32'h0,        32'h123455EF, 1'b0};

        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_func3 = '0;
        req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
`ifdef DMEM_ERR_STICKY_EN
        chk("reset err_sticky", 32'(err_sticky), 32'd0);
        chk("reset err_addr", err_addr, 32'd0);
`endif
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            do_req(vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wd,
                   vecs[i].exp_rd, vecs[i].exp_err, $sformatf("vec%0d", i));

`ifdef DMEM_ERR_STICKY_EN
        chk("sticky flag", 32'(err_sticky), 32'd1);
        chk("sticky addr", err_addr, 32'h2);
`endif

        // Backpressure: response held 5 cycles, second request waits for the bubble.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_func3 = 3'b010; req_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        req_addr = 32'h10; req_func3 = 3'b100;   // next request, kept valid
        n = 1;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("stall latency", 32'(n), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall%0d rdata", i), rsp_rdata, 32'h123455EF);
            chk($sformatf("stall%0d ready", i), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bubble valid", 32'(rsp_valid), 32'd0);
        chk("bubble ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("second latency", 32'(n), 32'(LAT));
        chk("second rdata", rsp_rdata, 32'h000000EF);
        @(negedge clk);

        // Reset while WAIT after an accepted store.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_func3 = 3'b010;
        req_wdata = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midreset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midreset req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_req(1'b0, 32'h20, 3'b010, 32'h0, 32'hA5A5A5A5, 1'b0, "after_reset");

        // Randomised traffic against the byte-array model.
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            ref_access(1'b1, 32'(4 * w), 3'b010, wd, erd, eerr);
            do_req(1'b1, 32'(4 * w), 3'b010, wd, erd, eerr, $sformatf("init%0d", w));
        end
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(12, 31));
            wd = $urandom;
            ref_access(we, a, f3, wd, erd, eerr);
            do_req(we, a, f3, wd, erd, eerr, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the load/store path; the far end of the control unit's load/store request (addr, rd_en/wr_en, func3).
- Accepts one request at a time over a valid/ready handshake and accesses an internal word-organised RAM with byte lanes.
- Returns load data already lane-shifted and sign/zero-extended per func3 (LB/LH/LW/LBU/LHU); stores use byte enables (SB/SH/SW).
- Flags misaligned, illegal-func3 and out-of-range accesses.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH words (default 4 KiB).
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_func3  in  3  RV32I load/store func3.
- req_wdata  in  32  store data; the relevant byte/half is in the low bits.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access faulted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. RAM contents are not reset.
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: counting down LATENCY-1 cycles.
  - RESP: rsp_valid=1, held until rsp_ready.
- Transitions:
  - IDLE→WAIT on req_valid&&req_ready when LATENCY>1.
  - IDLE→RESP directly when LATENCY=1.
  - WAIT→RESP when the counter reaches 0.
  - RESP→IDLE on rsp_ready.
- Latency: with rsp_ready=1, rsp_valid is high exactly LATENCY cycles after the acceptance edge. One bubble cycle follows each response; the next acceptance is at the earliest one cycle after the rsp handshake. req_ready=0 outside IDLE.
- Request capture: addr, we, func3 and wdata are registered at acceptance. Inputs changing afterwards have no effect.
- Error classification, done at acceptance:
  - misaligned: half access with addr[0]=1, or word access with addr[1:0]≠0.
  - illegal func3: loads 011/110/111; stores ≥011.
  - out of range: addr[31:ADDR_WIDTH+2]≠0.
  - On any error: no RAM write, rsp_err=1, rsp_rdata=0.
- Stores:
  - RAM write is committed on the acceptance edge.
  - Byte enables: SB = 1<<addr[1:0]; SH = 0011 or 1100 by addr[1]; SW = 1111.
  - wdata is replicated to the enabled lanes.
  - Response: rsp_err as classified, rsp_rdata=0.
- Loads:
  - The RAM word is read after acceptance and the selected lane is shifted to bit 0.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- Output stability: rsp_rdata and rsp_err are stable for the whole time rsp_valid=1, and are cleared to 0 on leaving RESP.
- Load after store to the same word: always returns the new data, since the write is committed before any later acceptance.
- Reset mid-operation: the pending response is dropped and the FSM returns to IDLE. A store already accepted stays written.
- Simultaneous events: rsp_ready without rsp_valid is ignored. req_valid outside IDLE is held off by req_ready=0; the requester must keep req_valid asserted.

Optional Feature:
- Macro: DMEM_ERR_STICKY_EN.
- When defined:
  - Adds outputs err_sticky (1 bit) and err_addr (32 bits).
  - err_sticky is set on the first faulting acceptance and holds until reset.
  - err_addr captures req_addr of that first fault only; later faults do not overwrite it.
  - Both reset to 0.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10, LATENCY=2, rsp_ready=1 → rsp_valid 2 cycles after each acceptance; rdata=0xDEADBEEF; err=0.
- After the store above: LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x10 → 0x0000BEEF.
- SB 0x55 @0x11, then LW @0x10 → 0xDEAD55EF; SH 0x1234 @0x12, then LW @0x10 → 0x123455EF.
- LW @0x02, SH @0x01, load func3=011, LW @0x00004000 (ADDR_WIDTH=10) → each gives rsp_err=1, rdata=0; a subsequent LW @0x10 shows memory unchanged.
- Hold rsp_ready=0 for 5 cycles during RESP → rsp_valid and rdata stable, req_ready=0; a new req_valid is not accepted until after the handshake plus one bubble.
- Assert rst=0 while in WAIT after an accepted SW 0xA5A5A5A5 @0x20 → rsp_valid=0 and req_ready=1 immediately; after release, LW @0x20 returns 0xA5A5A5A5.
- With DMEM_ERR_STICKY_EN: fault @0x02, then fault @0x05 → err_sticky=1 and err_addr=0x00000002 after both.
